// File: rtl/jtag_host.sv
// jtag_host: JTAG initiator, one 1-16 bit shift per request, slow TCK from i_clk.
// Optional macro JTAG_HOST_TDO_SYNCH_EN adds a 2-flop synchronizer on i_TDO.
module jtag_host #(
    parameter int CLK_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_reqValid,
    output logic        o_reqReady,
    input  logic [3:0]  i_reqLen,
    input  logic [15:0] i_reqTms,
    input  logic [15:0] i_reqTdi,
    output logic        o_rspValid,
    input  logic        i_rspReady,
    output logic [15:0] o_rspTdo,
    output logic        o_busy,
    output logic        o_TCK,
    output logic        o_TMS,
    output logic        o_TDI,
    input  logic        i_TDO
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} stateT;

    stateT       state, stateNext;
    logic [7:0]  divCnt;
    logic [3:0]  bitCnt;
    logic [3:0]  lenQ;
    logic [15:0] tmsSh;
    logic [15:0] tdiSh;
    logic [15:0] capSh;
    logic [15:0] rspTdoQ;
    logic        tckQ;
    logic        tmsQ;
    logic        tdiQ;
    logic        accept;
    logic        divEnd;
    logic        lastBit;
    logic        tdoS;

`ifdef JTAG_HOST_TDO_SYNCH_EN
    logic [1:0] tdoSync;

    // Two-flop synchronizer so a metastable TDO never reaches the capture reg
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tdoSync <= 2'b00;
        end else begin
            tdoSync <= {tdoSync[0], i_TDO};
        end
    end

    assign tdoS = tdoSync[1];

    divLegal: assert property (@(posedge i_clk) CLK_DIV >= 3);
`else
    assign tdoS = i_TDO;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state plus the per-cycle control strobes
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        divEnd    = (divCnt == 8'(CLK_DIV - 1));
        lastBit   = (bitCnt == lenQ);
        unique case (state)
            IDLE: begin
                if (i_reqValid) begin
                    accept    = 1'b1;
                    stateNext = LOW;
                end
            end
            LOW: begin
                if (divEnd) stateNext = HIGH;
            end
            HIGH: begin
                if (divEnd) stateNext = lastBit ? DONE : LOW;
            end
            DONE: begin
                if (i_rspReady) stateNext = IDLE;
            end
        endcase
    end

    // Datapath: TCK divider, bit shifting and TDO capture on the TCK fall
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            divCnt  <= '0;
            bitCnt  <= '0;
            lenQ    <= '0;
            tmsSh   <= '0;
            tdiSh   <= '0;
            capSh   <= '0;
            rspTdoQ <= '0;
            tckQ    <= 1'b0;
            tmsQ    <= 1'b1;
            tdiQ    <= 1'b0;
        end else if (accept) begin
            lenQ   <= i_reqLen;
            tmsQ   <= i_reqTms[0];
            tdiQ   <= i_reqTdi[0];
            tmsSh  <= {1'b0, i_reqTms[15:1]};
            tdiSh  <= {1'b0, i_reqTdi[15:1]};
            bitCnt <= '0;
            divCnt <= '0;
            capSh  <= '0;
        end else if (state == LOW) begin
            divCnt <= divEnd ? 8'd0 : divCnt + 8'd1;
            if (divEnd) tckQ <= 1'b1;
        end else if (state == HIGH) begin
            if (divEnd) begin
                divCnt        <= '0;
                tckQ          <= 1'b0;
                capSh[bitCnt] <= tdoS;
                if (lastBit) begin
                    rspTdoQ <= capSh | (16'(tdoS) << bitCnt);
                end else begin
                    bitCnt <= bitCnt + 4'd1;
                    tmsQ   <= tmsSh[0];
                    tdiQ   <= tdiSh[0];
                    tmsSh  <= {1'b0, tmsSh[15:1]};
                    tdiSh  <= {1'b0, tdiSh[15:1]};
                end
            end else begin
                divCnt <= divCnt + 8'd1;
            end
        end
    end

    assign o_reqReady = (state == IDLE);
    assign o_rspValid = (state == DONE);
    assign o_busy     = (state == LOW) || (state == HIGH);
    assign o_rspTdo   = rspTdoQ;
    assign o_TCK      = tckQ;
    assign o_TMS      = tmsQ;
    assign o_TDI      = tdiQ;

endmodule

// File: tb/tb_jtag_host.sv
// tb_jtag_host: directed bench for jtag_host with loopback and stuck TDO.
// Uses CLK_DIV=3 when JTAG_HOST_TDO_SYNCH_EN is defined, else 4.
module tb_jtag_host;

`ifdef JTAG_HOST_TDO_SYNCH_EN
    localparam int DIV = 3;
`else
    localparam int DIV = 4;
`endif

    logic        clk;
    logic        rstn;
    logic        reqValid;
    logic        reqReady;
    logic [3:0]  reqLen;
    logic [15:0] reqTms;
    logic [15:0] reqTdi;
    logic        rspValid;
    logic        rspReady;
    logic [15:0] rspTdo;
    logic        busy;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic        loopMode;
    logic        stuckVal;

    int errors = 0;
    int checks = 0;

    jtag_host #(.CLK_DIV(DIV)) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_reqValid (reqValid),
        .o_reqReady (reqReady),
        .i_reqLen   (reqLen),
        .i_reqTms   (reqTms),
        .i_reqTdi   (reqTdi),
        .o_rspValid (rspValid),
        .i_rspReady (rspReady),
        .o_rspTdo   (rspTdo),
        .o_busy     (busy),
        .o_TCK      (tck),
        .o_TMS      (tms),
        .o_TDI      (tdi),
        .i_TDO      (tdo)
    );

    assign tdo = loopMode ? tdi : stuckVal;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request and observe until rspValid (cycle 1 = first negedge
    // after the accept edge).
    task automatic runReq(input logic [3:0] len, input logic [15:0] tmsV,
                          input logic [15:0] tdiV, output logic [15:0] gotTdo,
                          output int lat, output int rises,
                          output logic [15:0] tmsSeq,
                          output logic [15:0] tdiSeq,
                          output logic viol, output logic timedOut);
        logic pTck, pTms, pTdi;
        gotTdo   = '0;
        lat      = -1;
        rises    = 0;
        tmsSeq   = '0;
        tdiSeq   = '0;
        viol     = 1'b0;
        timedOut = 1'b1;
        pTck     = 1'b0;
        pTms     = 1'b0;
        pTdi     = 1'b0;
        @(negedge clk);
        reqValid = 1'b1;
        reqLen   = len;
        reqTms   = tmsV;
        reqTdi   = tdiV;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        reqLen   = 4'($urandom);
        reqTms   = 16'($urandom);
        reqTdi   = 16'($urandom);
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n > 1 && pTck && tck && (tms !== pTms || tdi !== pTdi))
                viol = 1'b1;
            if (tck && !pTck) begin
                if (rises < 16) begin
                    tmsSeq[rises] = tms;
                    tdiSeq[rises] = tdi;
                end
                rises++;
            end
            pTck = tck;
            pTms = tms;
            pTdi = tdi;
            if (rspValid) begin
                lat      = n;
                gotTdo   = rspTdo;
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic consume();
        @(negedge clk);
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        rspReady = 1'b0;
        @(negedge clk);
        check("readyAfterConsume", reqReady, 1);
        check("validAfterConsume", rspValid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] got, tmsSeq, tdiSeq;
        int          lat, rises;
        logic        viol, tOut;
        int          badReady, badTdo, badValid, seen;

        rstn     = 1'b0;
        reqValid = 1'b0;
        reqLen   = '0;
        reqTms   = '0;
        reqTdi   = '0;
        rspReady = 1'b0;
        loopMode = 1'b1;
        stuckVal = 1'b0;

        repeat (3) @(negedge clk);
        check("rstTck", tck, 0);
        check("rstTms", tms, 1);
        check("rstTdi", tdi, 0);
        check("rstReqReady", reqReady, 1);
        check("rstRspValid", rspValid, 0);
        check("rstRspTdo", rspTdo, 0);
        check("rstBusy", busy, 0);
        rstn = 1'b1;

        // Loopback, 4 bits
        runReq(4'd3, 16'h0000, 16'h000A, got, lat, rises, tmsSeq, tdiSeq,
               viol, tOut);
        check("t1Timeout", tOut, 0);
        check("t1Tdo", got, 16'h000A);
        check("t1Lat", lat, 1 + 2 * DIV * 4);
        check("t1Rises", rises, 4);
        check("t1TdiSeq", tdiSeq[3:0], 4'hA);
        check("t1Viol", viol, 0);
        consume();

        // Full width
        runReq(4'd15, 16'h0000, 16'h8001, got, lat, rises, tmsSeq, tdiSeq,
               viol, tOut);
        check("t2Timeout", tOut, 0);
        check("t2Tdo", got, 16'h8001);
        check("t2Lat", lat, 1 + 2 * DIV * 16);
        check("t2Rises", rises, 16);
        check("t2TdiSeq", tdiSeq, 16'h8001);
        consume();

        // TMS walk
        runReq(4'd4, 16'h0015, 16'h000A, got, lat, rises, tmsSeq, tdiSeq,
               viol, tOut);
        check("t3Timeout", tOut, 0);
        check("t3TmsSeq", tmsSeq[4:0], 5'h15);
        check("t3Rises", rises, 5);
        check("t3Viol", viol, 0);
        check("t3Tdo", got, 16'h000A);
        consume();

        // Backpressure
        runReq(4'd5, 16'h0000, 16'h002D, got, lat, rises, tmsSeq, tdiSeq,
               viol, tOut);
        check("t4Timeout", tOut, 0);
        check("t4Tdo", got, 16'h002D);
        badReady = 0;
        badTdo   = 0;
        badValid = 0;
        @(negedge clk);
        reqValid = 1'b1;
        reqLen   = 4'd1;
        reqTms   = 16'hFFFF;
        reqTdi   = 16'h0003;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (reqReady !== 1'b0) badReady++;
            if (rspTdo !== 16'h002D) badTdo++;
            if (rspValid !== 1'b1) badValid++;
        end
        check("t4ReadyLow", badReady, 0);
        check("t4TdoStable", badTdo, 0);
        check("t4ValidHeld", badValid, 0);
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        rspReady = 1'b0;
        reqValid = 1'b0;
        @(negedge clk);
        check("t4ReadyNext", reqReady, 1);
        check("t4ValidLow", rspValid, 0);
        check("t4TdoHold", rspTdo, 16'h002D);

        // Reset mid-shift
        @(negedge clk);
        reqValid = 1'b1;
        reqLen   = 4'd7;
        reqTms   = 16'h0000;
        reqTdi   = 16'h00FF;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        repeat (10) @(negedge clk);
        check("t5BusyBefore", busy, 1);
        check("t5TmsBefore", tms, 0);
        #2;
        rstn = 1'b0;
        #1;
        check("t5Tck", tck, 0);
        check("t5Tms", tms, 1);
        check("t5Busy", busy, 0);
        check("t5RspValid", rspValid, 0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (rspValid) seen++;
        end
        check("t5NoRsp", seen, 0);
        check("t5Ready", reqReady, 1);

        // Stuck TDO=1
        loopMode = 1'b0;
        stuckVal = 1'b1;
        runReq(4'd2, 16'h0000, 16'h0000, got, lat, rises, tmsSeq, tdiSeq,
               viol, tOut);
        check("t6Timeout", tOut, 0);
        check("t6Tdo", got, 16'h0007);
        check("t6Lat", lat, 1 + 2 * DIV * 3);
        check("t6Rises", rises, 3);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
